// File: rtl/spi_master_32_if.sv
// Bus bundle for spi_master_32: control handshake plus SPI pins.
// cs_n exists only when SPI_MASTER_CS_EN is defined.
interface spi_master_32_if #(
  parameter int unsigned FRAME_BITS = 32
);
  logic                  start;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  sck;
  logic                  sdo;
  logic                  sdi;
`ifdef SPI_MASTER_CS_EN
  logic                  cs_n;

  modport master (
    input  start, tx_data, sdi,
    output busy, done, rx_data, sck, sdo, cs_n
  );

  modport slave (
    output start, tx_data, sdi,
    input  busy, done, rx_data, sck, sdo, cs_n
  );
`else
  modport master (
    input  start, tx_data, sdi,
    output busy, done, rx_data, sck, sdo
  );

  modport slave (
    output start, tx_data, sdi,
    input  busy, done, rx_data, sck, sdo
  );
`endif
endinterface

// File: rtl/spi_master_32.sv
// Mode-0 SPI master running FRAME_BITS full-duplex frames, MSB first.
// Optional chip select with minimum high time: define SPI_MASTER_CS_EN.
module spi_master_32 #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  spi_master_32_if.master bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic                  accept;

`ifdef SPI_MASTER_CS_EN
  localparam int unsigned GAP_W = $clog2(CLK_DIV + 1);
  logic [GAP_W-1:0] gap_cnt;

  // gap_cnt enforces the cs_n high time between frames
  always_comb begin
    accept = (state == IDLE) && bus.start && (gap_cnt == '0);
  end
`else
  always_comb begin
    accept = (state == IDLE) && bus.start;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bus.sck     <= 1'b0;
      bus.sdo     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rx_data <= '0;
`ifdef SPI_MASTER_CS_EN
      bus.cs_n    <= 1'b1;
      gap_cnt     <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.sck <= 1'b0;
          if (accept) begin
            tx_sr    <= bus.tx_data;
            bus.sdo  <= bus.tx_data[FRAME_BITS-1];
            bus.busy <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
`ifdef SPI_MASTER_CS_EN
            bus.cs_n <= 1'b0;
`endif
          end
`ifdef SPI_MASTER_CS_EN
          else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
`endif
        end
        SHIFT: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            bus.sck <= ~bus.sck;
            if (!bus.sck) begin
              rx_sr <= {rx_sr[FRAME_BITS-2:0], bus.sdi};
            end else if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
              // last falling edge closes the frame; rx_sr already holds every bit
              state       <= IDLE;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              bus.rx_data <= rx_sr;
              bus.sdo     <= 1'b0;
`ifdef SPI_MASTER_CS_EN
              bus.cs_n    <= 1'b1;
              gap_cnt     <= GAP_W'(CLK_DIV);
`endif
            end else begin
              tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
              bus.sdo <= tx_sr[FRAME_BITS-2];
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_32.sv
// Directed bench for spi_master_32: one instance at CLK_DIV=4, one at CLK_DIV=1,
// with an inline slave model that captures sdo and feeds sdi on rising sck.
module tb_spi_master_32;

  logic        clk = 1'b0;
  logic        reset_r = 1'b1;
  logic        sel = 1'b0;
  logic        start_r = 1'b0;
  logic [31:0] tx_r = '0;
  logic        sdi_r = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_master_32_if #(.FRAME_BITS(32)) b4 ();
  spi_master_32_if #(.FRAME_BITS(32)) b1 ();

  assign b4.start   = start_r & ~sel;
  assign b1.start   = start_r & sel;
  assign b4.tx_data = tx_r;
  assign b1.tx_data = tx_r;
  assign b4.sdi     = sdi_r;
  assign b1.sdi     = sdi_r;

  spi_master_32 #(.CLK_DIV(4), .FRAME_BITS(32)) dut4 (.clk(clk), .reset(reset_r), .bus(b4.master));
  spi_master_32 #(.CLK_DIV(1), .FRAME_BITS(32)) dut1 (.clk(clk), .reset(reset_r), .bus(b1.master));

  logic        cur_sck, cur_sdo, cur_busy, cur_done;
  logic [31:0] cur_rx;
  assign cur_sck  = sel ? b1.sck     : b4.sck;
  assign cur_sdo  = sel ? b1.sdo     : b4.sdo;
  assign cur_busy = sel ? b1.busy    : b4.busy;
  assign cur_done = sel ? b1.done    : b4.done;
  assign cur_rx   = sel ? b1.rx_data : b4.rx_data;

  int          rises, toggles, busy_cnt, done_cnt;
  logic [31:0] sdo_cap;
  logic        first_busy, aborted, timed_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge of the done cycle (or after abort).
  task automatic frame(input logic [31:0] word, input logic [31:0] slv, input logic [31:0] nxt,
                       input bit hold, input int poke_rise, input int abort_rise);
    logic [31:0] slv_sr;
    logic        prev;
    bit          poked;
    slv_sr = slv;
    start_r = 1'b1; tx_r = word; sdi_r = slv_sr[31];
    rises = 0; toggles = 0; busy_cnt = 0; done_cnt = 0; sdo_cap = '0;
    first_busy = 1'b0; aborted = 1'b0; timed_out = 1'b1;
    prev = cur_sck; poked = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) first_busy = cur_busy;
      if (hold) begin
        start_r = 1'b1; tx_r = nxt;
      end else begin
        start_r = 1'b0; tx_r = $urandom;
      end
      if (cur_busy) busy_cnt++;
      if (cur_sck != prev) toggles++;
      if (cur_sck && !prev) begin
        rises++;
        sdo_cap = {sdo_cap[30:0], cur_sdo};
        slv_sr  = {slv_sr[30:0], 1'b0};
        sdi_r   = slv_sr[31];
      end
      prev = cur_sck;
      if (poke_rise >= 0 && rises == poke_rise && !poked) begin
        start_r = 1'b1; tx_r = 32'hFFFF_FFFF; poked = 1'b1;
      end
      if (cur_done) begin
        done_cnt++; timed_out = 1'b0;
        break;
      end
      if (abort_rise >= 0 && rises == abort_rise) begin
        reset_r = 1'b1; start_r = 1'b0;
        @(negedge clk);
        reset_r = 1'b0; aborted = 1'b1; timed_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int seen;
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_r = 1'($urandom); tx_r = $urandom; sdi_r = 1'($urandom);
    end
    @(negedge clk);
    check("rst_sck",  32'(cur_sck),  0);
    check("rst_sdo",  32'(cur_sdo),  0);
    check("rst_busy", 32'(cur_busy), 0);
    check("rst_done", 32'(cur_done), 0);
    check("rst_rx",   cur_rx,        0);
`ifdef SPI_MASTER_CS_EN
    check("rst_cs_n", 32'(b4.cs_n),  1);
`endif
    reset_r = 1'b0; start_r = 1'b0;
    @(negedge clk);

    // single frame
    frame(32'hA5A5_0F0F, 32'h0000_02AB, '0, 1'b0, -1, -1);
    check("f1_timeout", 32'(timed_out), 0);
    check("f1_first_busy", 32'(first_busy), 1);
    check("f1_rises", rises, 32);
    check("f1_busy_cycles", busy_cnt, 256);
    check("f1_sdo", sdo_cap, 32'hA5A5_0F0F);
    check("f1_rx", cur_rx, 32'h0000_02AB);
    @(negedge clk);
    check("f1_done_width", 32'(cur_done), 0);
    check("f1_rx_hold", cur_rx, 32'h0000_02AB);

    // start while busy at bit 10
    frame(32'h3C3C_C3C3, 32'hDEAD_BEEF, '0, 1'b0, 10, -1);
    check("poke_timeout", 32'(timed_out), 0);
    check("poke_rises", rises, 32);
    check("poke_busy_cycles", busy_cnt, 256);
    check("poke_sdo", sdo_cap, 32'h3C3C_C3C3);
    check("poke_rx", cur_rx, 32'hDEAD_BEEF);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_busy) seen++;
    end
    check("poke_no_second", seen, 0);

    // back-to-back
    frame(32'h0F0F_0F0F, 32'h1111_1111, 32'h1234_5678, 1'b1, -1, -1);
    check("b2b1_timeout", 32'(timed_out), 0);
    check("b2b1_sdo", sdo_cap, 32'h0F0F_0F0F);
    check("b2b1_rx", cur_rx, 32'h1111_1111);
    frame(32'h1234_5678, 32'h8765_4321, '0, 1'b0, -1, -1);
    check("b2b2_timeout", 32'(timed_out), 0);
`ifdef SPI_MASTER_CS_EN
    check("b2b2_first_busy", 32'(first_busy), 0);
`else
    check("b2b2_first_busy", 32'(first_busy), 1);
`endif
    check("b2b2_busy_cycles", busy_cnt, 256);
    check("b2b2_sdo", sdo_cap, 32'h1234_5678);
    check("b2b2_rx", cur_rx, 32'h8765_4321);
    @(negedge clk);

    // reset mid-frame at rising edge 16
    frame(32'hCAFE_F00D, 32'h5555_AAAA, '0, 1'b0, -1, 16);
    check("abort_taken", 32'(aborted), 1);
    check("abort_no_done", done_cnt, 0);
    check("abort_sck", 32'(cur_sck), 0);
    check("abort_busy", 32'(cur_busy), 0);
    check("abort_done", 32'(cur_done), 0);
    check("abort_rx", cur_rx, 0);
    frame(32'h0000_FFFF, 32'hA0A0_A0A0, '0, 1'b0, -1, -1);
    check("fresh_timeout", 32'(timed_out), 0);
    check("fresh_sdo", sdo_cap, 32'h0000_FFFF);
    check("fresh_rx", cur_rx, 32'hA0A0_A0A0);
    @(negedge clk);

    // CLK_DIV=1 instance
    sel = 1'b1;
    @(negedge clk);
    frame(32'h8000_0001, 32'hFFFF_FFFF, '0, 1'b0, -1, -1);
    check("div1_timeout", 32'(timed_out), 0);
    check("div1_busy_cycles", busy_cnt, 64);
    check("div1_toggles", toggles, 64);
    check("div1_rises", rises, 32);
    check("div1_sdo", sdo_cap, 32'h8000_0001);
    check("div1_rx", cur_rx, 32'hFFFF_FFFF);
    @(negedge clk);
    check("div1_done_width", 32'(cur_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
